classifier_argmax: RTL and testbench
====================================

# classifier_argmax

Downstream consumer of `neural_network`: captures the final-layer activation vector when the network signals completion, scans it sequentially one element per cycle, and reports the index of the largest activation as the predicted class. It runs in the same clock domain as the network, connects directly to the network's `outputs` / `outputs_ready`, and holds its result until the system acknowledges it.

## Interface
Activations use the shared signed fixed-point format `[INTEGER_WIDTH-1:-FRACTION_WIDTH]` from `include.svh`. `INDEX_WIDTH = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1`.

Parameters:
- `NUM_CLASSES`, default 10: vector length; must match the final layer size; legal range 1..256.
- `THRESHOLD`, default 0: signed fixed-point rejection threshold; used only with `ARGMAX_THRESHOLD_EN`.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `scores_ready`  in  1  network `outputs_ready`; a rising edge marks a new vector.
- `scores[NUM_CLASSES]`  in  INTEGER_WIDTH+FRACTION_WIDTH each, signed  network `outputs`.
- `busy`  out  1  high in SCAN.
- `class_valid`  out  1  result available; high in DONE.
- `class_index`  out  INDEX_WIDTH  index of the maximum activation.
- `max_score`  out  INTEGER_WIDTH+FRACTION_WIDTH, signed  value of the maximum activation.
- `rejected`  out  1  maximum is below `THRESHOLD`; see Configuration.
- `result_ack`  in  1  consumer has taken the result.
- `dropped`  out  1  one-cycle pulse: a rising edge arrived while not IDLE and was discarded.

## Operation
- Edge detect: `ready_q` registers `scores_ready`. Start condition is `scores_ready & ~ready_q`. A level held high starts exactly once.
- States: IDLE, SCAN, DONE.
- IDLE:
  - On start, copy all of `scores` into the internal buffer.
  - Set `best = scores[0]`, `best_idx = 0`, `i = 1`.
  - Go to SCAN; if `NUM_CLASSES == 1`, go straight to DONE.
- SCAN, each cycle:
  - If `buf[i] > best` (signed, strictly greater), then `best <= buf[i]` and `best_idx <= i`.
  - Ties keep the lowest index.
  - If `i == NUM_CLASSES-1`, go to DONE; otherwise `i <= i+1`.
- DONE:
  - `class_index`, `max_score` and `rejected` are held stable.
  - When `result_ack` is high, return to IDLE on that edge.
- Comparison is full-width signed. There is no saturation and no arithmetic beyond compare.
- Start edges in SCAN or DONE are ignored. Each one pulses `dropped` for one cycle. The buffer is not overwritten.
- `result_ack` outside DONE has no effect.
- The input vector only needs to be stable in the capture cycle; later changes do not affect the result.

## Timing
- Reset values: state IDLE, `busy = 0`, `class_valid = 0`, `class_index = 0`, `max_score = 0`, `rejected = 0`, `dropped = 0`, `ready_q = 0`, buffer cleared.
- Reset is asynchronous and takes effect mid-SCAN or in DONE. Any result in progress is lost.
- `ready_q` resets to 0. A `scores_ready` that is already high when reset releases is therefore seen as an edge and starts a scan.
- Latency: capture on edge k; `class_valid` rises after edge k+NUM_CLASSES-1 (edge k when `NUM_CLASSES == 1`).
- `busy` is high from edge k until edge k+NUM_CLASSES-1.
- `class_valid` falls on the edge where `result_ack` is sampled high.
- Earliest next capture is the following edge, if a fresh rising edge of `scores_ready` occurs there.
- Throughput: one vector per NUM_CLASSES+1 cycles, given immediate ack.
- All outputs are registered.

## Configuration
- `ARGMAX_THRESHOLD_EN` defined: on entry to DONE, `rejected <= (best < THRESHOLD)` (signed compare). `class_index` is still reported.
- `ARGMAX_THRESHOLD_EN` undefined: `rejected` is tied to 0, no comparator is built, and `THRESHOLD` is ignored.

## Test plan
- Distinct maximum: NUM_CLASSES=10, scores 0.1 everywhere except `scores[7] = 0.75`, edge on `scores_ready`. Required: `class_valid` 9 cycles after capture, `class_index = 7`, `max_score = 0.75`.
- Tie and negatives: scores all −0.5 except `scores[2] = scores[5] = 0.25`. Required: `class_index = 2`. Separately, all scores −1.0. Required: `class_index = 0`, `max_score = −1.0`.
- Handshake and held level: keep `scores_ready` high for 30 cycles and delay `result_ack` by 5 cycles after `class_valid`. Required: exactly one scan, no `dropped`, outputs stable until the ack edge, `class_valid` low the cycle after the ack.
- Overrun: issue a second rising edge during SCAN. Required: a one-cycle `dropped` pulse, and the first vector's result is unchanged.
- Reset mid-scan: assert `reset` at SCAN step 4. Required: all outputs immediately at reset values; after release, a new edge yields a correct result.
- Threshold: with `ARGMAX_THRESHOLD_EN`, `THRESHOLD = 0.5` and max 0.25, `rejected = 1`; with max 0.5, `rejected = 0`. Without the macro, `rejected = 0` in both cases.

Source files
------------

// File: rtl/classifier_argmax_if.sv
// -----------------------------------------------------------------------------
// classifier_argmax_if
//
// Bundles the activation-vector handshake and the result outputs of
// classifier_argmax. The network-side/system-side testbench or wrapper uses the
// master modport. The argmax block uses the slave modport.
//
// Parameters:
//   NUM_CLASSES  activation vector length (1..256)
//   DATA_W       activation width, INTEGER_WIDTH+FRACTION_WIDTH
//   INDEX_WIDTH  width of the class index
//
// Signals:
//   scores_ready  network outputs_ready; its rising edge marks a new vector
//   scores        signed activation vector, NUM_CLASSES entries
//   result_ack    consumer has taken the result
//   busy          scan in progress
//   class_valid   result available
//   class_index   index of the maximum activation
//   max_score     value of the maximum activation
//   rejected      maximum below the configured threshold
//   dropped       one-cycle pulse for a discarded start edge
// -----------------------------------------------------------------------------
interface classifier_argmax_if #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 16,
    parameter int INDEX_WIDTH = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
);
    logic                    scores_ready;
    logic signed [DATA_W-1:0] scores [NUM_CLASSES];
    logic                    result_ack;
    logic                    busy;
    logic                    class_valid;
    logic [INDEX_WIDTH-1:0]  class_index;
    logic signed [DATA_W-1:0] max_score;
    logic                    rejected;
    logic                    dropped;

    modport master (
        output scores_ready, scores, result_ack,
        input  busy, class_valid, class_index, max_score, rejected, dropped
    );

    modport slave (
        input  scores_ready, scores, result_ack,
        output busy, class_valid, class_index, max_score, rejected, dropped
    );
endinterface

// File: rtl/classifier_argmax.sv
// -----------------------------------------------------------------------------
// classifier_argmax
//
// Captures the final-layer activation vector on a rising edge of scores_ready.
// It then scans the captured copy one element per cycle and reports the index
// and value of the largest activation. The result is held until result_ack.
// When values tie, the lowest index is kept.
//
// Optional feature macro: ARGMAX_THRESHOLD_EN
//   defined   -> rejected is set on entry to DONE when max < THRESHOLD (signed)
//   undefined -> rejected is tied low and THRESHOLD is ignored
//
// Ports:
//   clock  single clock, rising edge
//   reset  asynchronous, active-high
//   s      classifier_argmax_if.slave
//            in : scores_ready, scores[NUM_CLASSES], result_ack
//            out: busy, class_valid, class_index, max_score, rejected, dropped
//
// Parameters:
//   NUM_CLASSES     vector length, 1..256
//   INTEGER_WIDTH   integer bits of the shared signed fixed-point format
//   FRACTION_WIDTH  fraction bits of the shared signed fixed-point format
//   THRESHOLD       signed fixed-point rejection threshold
// -----------------------------------------------------------------------------
module classifier_argmax #(
    parameter int NUM_CLASSES    = 10,
    parameter int INTEGER_WIDTH  = 8,
    parameter int FRACTION_WIDTH = 8,
    parameter logic signed [INTEGER_WIDTH+FRACTION_WIDTH-1:0] THRESHOLD = '0
) (
    input  logic            clock,
    input  logic            reset,
    classifier_argmax_if.slave s
);
    localparam int DATA_W      = INTEGER_WIDTH + FRACTION_WIDTH;
    localparam int INDEX_WIDTH = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full-width signed compare; strict so that ties keep the earlier index.
    function automatic logic is_greater(input logic signed [DATA_W-1:0] a,
                                        input logic signed [DATA_W-1:0] b);
        return a > b;
    endfunction

`ifdef ARGMAX_THRESHOLD_EN
    function automatic logic is_below(input logic signed [DATA_W-1:0] a,
                                      input logic signed [DATA_W-1:0] b);
        return a < b;
    endfunction
`endif

    state_t                   state;
    logic                     ready_q;
    logic                     start;
    logic signed [DATA_W-1:0] score_buf [NUM_CLASSES];
    logic signed [DATA_W-1:0] best;
    logic [INDEX_WIDTH-1:0]   best_idx;
    logic [INDEX_WIDTH-1:0]   idx;

    logic                     busy_q;
    logic                     class_valid_q;
    logic [INDEX_WIDTH-1:0]   class_index_q;
    logic signed [DATA_W-1:0] max_score_q;
    logic                     dropped_q;

    // Running-maximum candidate for the element under scan this cycle.
    logic signed [DATA_W-1:0] cur_score;
    logic                     take;
    logic signed [DATA_W-1:0] nxt_best;
    logic [INDEX_WIDTH-1:0]   nxt_idx;

    // A level held high starts only once; ready_q is cleared by reset, so a
    // level already high at release counts as a fresh edge.
    assign start = s.scores_ready & ~ready_q;

    always_comb begin
        cur_score = score_buf[idx];
        take      = is_greater(cur_score, best);
        nxt_best  = take ? cur_score : best;
        nxt_idx   = take ? idx : best_idx;
    end

`ifdef ARGMAX_THRESHOLD_EN
    logic rejected_q;
`else
    logic unused_threshold;
    assign unused_threshold = ^THRESHOLD;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ready_q       <= 1'b0;
            busy_q        <= 1'b0;
            class_valid_q <= 1'b0;
            class_index_q <= '0;
            max_score_q   <= '0;
            dropped_q     <= 1'b0;
            best          <= '0;
            best_idx      <= '0;
            idx           <= '0;
            for (int n = 0; n < NUM_CLASSES; n++) begin
                score_buf[n] <= '0;
            end
`ifdef ARGMAX_THRESHOLD_EN
            rejected_q    <= 1'b0;
`endif
        end else begin
            ready_q   <= s.scores_ready;
            // Edges that arrive while a vector is in flight or held are discarded.
            dropped_q <= start && (state != IDLE);

            case (state)
                IDLE: begin
                    if (start) begin
                        for (int n = 0; n < NUM_CLASSES; n++) begin
                            score_buf[n] <= s.scores[n];
                        end
                        best     <= s.scores[0];
                        best_idx <= '0;
                        idx      <= INDEX_WIDTH'(1);
                        if (NUM_CLASSES == 1) begin
                            // A single-element vector needs no scan.
                            state         <= DONE;
                            class_valid_q <= 1'b1;
                            class_index_q <= '0;
                            max_score_q   <= s.scores[0];
`ifdef ARGMAX_THRESHOLD_EN
                            rejected_q    <= is_below(s.scores[0], THRESHOLD);
`endif
                        end else begin
                            state  <= SCAN;
                            busy_q <= 1'b1;
                        end
                    end
                end

                SCAN: begin
                    best     <= nxt_best;
                    best_idx <= nxt_idx;
                    if (idx == LAST_IDX) begin
                        // Publish the result from the final compare directly.
                        // This makes it valid on the same edge.
                        state         <= DONE;
                        busy_q        <= 1'b0;
                        class_valid_q <= 1'b1;
                        class_index_q <= nxt_idx;
                        max_score_q   <= nxt_best;
`ifdef ARGMAX_THRESHOLD_EN
                        rejected_q    <= is_below(nxt_best, THRESHOLD);
`endif
                    end else begin
                        idx <= idx + INDEX_WIDTH'(1);
                    end
                end

                DONE: begin
                    if (s.result_ack) begin
                        state         <= IDLE;
                        class_valid_q <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign s.busy        = busy_q;
    assign s.class_valid = class_valid_q;
    assign s.class_index = class_index_q;
    assign s.max_score   = max_score_q;
    assign s.dropped     = dropped_q;
`ifdef ARGMAX_THRESHOLD_EN
    assign s.rejected    = rejected_q;
`else
    assign s.rejected    = 1'b0;
`endif

endmodule

// File: tb/tb_classifier_argmax.sv
// -----------------------------------------------------------------------------
// tb_classifier_argmax
//
// Self-checking bench for classifier_argmax with NUM_CLASSES=10 and Q8.8
// activations. Expected results come from a plain argmax over the stimulus
// array held in the bench. The expected rejected flag follows
// ARGMAX_THRESHOLD_EN.
// -----------------------------------------------------------------------------
module tb_classifier_argmax;
    localparam int N  = 10;
    localparam int IW = 8;
    localparam int FW = 8;
    localparam int DW = IW + FW;
    localparam logic signed [DW-1:0] THR = 16'sd128;  // 0.5

    // Q8.8 constants
    localparam int P0_1  = 26;    // 0.1
    localparam int P0_25 = 64;
    localparam int P0_5  = 128;
    localparam int P0_75 = 192;
    localparam int M0_5  = -128;
    localparam int M1_0  = -256;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    classifier_argmax_if #(.NUM_CLASSES(N), .DATA_W(DW)) bus ();

    classifier_argmax #(
        .NUM_CLASSES(N), .INTEGER_WIDTH(IW), .FRACTION_WIDTH(FW), .THRESHOLD(THR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .s    (bus.slave)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int drop_seen = 0;
    logic signed [DW-1:0] vec [N];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        drop_seen += int'(bus.dropped);
    endtask

    // Reference model: first index holding the largest value.
    function automatic int ref_idx();
        int b = 0;
        for (int n = 1; n < N; n++) if (vec[n] > vec[b]) b = n;
        return b;
    endfunction

    function automatic int ref_max();
        return int'(vec[ref_idx()]);
    endfunction

    function automatic int ref_rej();
`ifdef ARGMAX_THRESHOLD_EN
        return (ref_max() < int'(THR)) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic apply_vec();
        for (int n = 0; n < N; n++) bus.scores[n] = vec[n];
    endtask

    task automatic scramble();
        for (int n = 0; n < N; n++) bus.scores[n] = DW'($urandom);
    endtask

    task automatic fill(input int base);
        for (int n = 0; n < N; n++) vec[n] = DW'(base);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.class_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_result(input string tag);
        check({tag, ".valid"}, bus.class_valid, 1);
        check({tag, ".idx"},   bus.class_index, ref_idx());
        check({tag, ".max"},   bus.max_score,   ref_max());
        check({tag, ".rej"},   bus.rejected,    ref_rej());
        check({tag, ".busy"},  bus.busy,        0);
    endtask

    // One complete transaction: edge, scan, result, immediate ack.
    task automatic run_vec(input string tag);
        int lat;
        bus.scores_ready = 1'b0;
        tick();
        apply_vec();
        bus.scores_ready = 1'b1;
        tick();
        check({tag, ".busy_cap"}, bus.busy, 1);
        bus.scores_ready = 1'b0;
        scramble();
        wait_valid(lat);
        check({tag, ".latency"}, lat, N - 1);
        check_result(tag);
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        check({tag, ".ack"}, bus.class_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int db;
        int any_busy;
        int any_valid;

        reset = 1'b1;
        bus.scores_ready = 1'b0;
        bus.result_ack = 1'b0;
        for (int n = 0; n < N; n++) bus.scores[n] = '0;
        tick();
        tick();
        check("rst.busy",  bus.busy, 0);
        check("rst.valid", bus.class_valid, 0);
        check("rst.idx",   bus.class_index, 0);
        check("rst.max",   bus.max_score, 0);
        check("rst.rej",   bus.rejected, 0);
        check("rst.drop",  bus.dropped, 0);

        // scores_ready already high when reset releases counts as an edge.
        fill(P0_1);
        vec[4] = DW'(P0_5);
        apply_vec();
        bus.scores_ready = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("relhigh.busy", bus.busy, 1);
        bus.scores_ready = 1'b0;
        wait_valid(lat);
        check("relhigh.latency", lat, N - 1);
        check_result("relhigh");
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;

        // Distinct maximum
        fill(P0_1);
        vec[7] = DW'(P0_75);
        run_vec("distinct");

        // Ties keep the lowest index
        fill(M0_5);
        vec[2] = DW'(P0_25);
        vec[5] = DW'(P0_25);
        run_vec("tie");

        // All equal and negative
        fill(M1_0);
        run_vec("allneg");

        // Threshold boundaries: max below, then exactly equal
        fill(M0_5);
        vec[3] = DW'(P0_25);
        run_vec("thr_below");
        fill(M0_5);
        vec[4] = DW'(P0_5);
        run_vec("thr_equal");

        // Held level with delayed ack
        fill(P0_1);
        vec[7] = DW'(P0_75);
        bus.scores_ready = 1'b0;
        tick();
        apply_vec();
        bus.scores_ready = 1'b1;
        db = drop_seen;
        tick();
        scramble();
        wait_valid(lat);
        check("held.latency", lat, N - 1);
        check_result("held");
        for (int c = 0; c < 5; c++) begin
            tick();
            check("held.stable_valid", bus.class_valid, 1);
            check("held.stable_idx", bus.class_index, ref_idx());
            check("held.stable_max", bus.max_score, ref_max());
        end
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        check("held.ack", bus.class_valid, 0);
        any_busy = 0;
        any_valid = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            any_busy |= int'(bus.busy);
            any_valid |= int'(bus.class_valid);
        end
        check("held.rescan_busy", any_busy, 0);
        check("held.rescan_valid", any_valid, 0);
        check("held.no_drop", drop_seen - db, 0);
        bus.scores_ready = 1'b0;

        // Overrun: second edge during SCAN
        for (int n = 0; n < N; n++) vec[n] = DW'($urandom);
        bus.scores_ready = 1'b0;
        tick();
        apply_vec();
        bus.scores_ready = 1'b1;
        tick();
        bus.scores_ready = 1'b0;
        scramble();
        tick();
        tick();
        db = drop_seen;
        bus.scores_ready = 1'b1;
        tick();
        check("ovr.drop_pulse", bus.dropped, 1);
        bus.scores_ready = 1'b0;
        tick();
        check("ovr.drop_end", bus.dropped, 0);
        check("ovr.drop_count", drop_seen - db, 1);
        wait_valid(lat);
        check("ovr.latency", lat, N - 1 - 4);
        check_result("ovr");
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;

        // Reset at SCAN step 4
        for (int n = 0; n < N; n++) vec[n] = DW'($urandom);
        bus.scores_ready = 1'b0;
        tick();
        apply_vec();
        bus.scores_ready = 1'b1;
        tick();
        bus.scores_ready = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        #2;
        reset = 1'b1;
        #1;
        check("mrst.busy",  bus.busy, 0);
        check("mrst.valid", bus.class_valid, 0);
        check("mrst.idx",   bus.class_index, 0);
        check("mrst.max",   bus.max_score, 0);
        check("mrst.rej",   bus.rejected, 0);
        check("mrst.drop",  bus.dropped, 0);
        tick();
        reset = 1'b0;
        tick();
        check("mrst.idle_busy", bus.busy, 0);
        for (int n = 0; n < N; n++) vec[n] = DW'($urandom);
        run_vec("mrst.after");

        // Randomized vectors: wide random, tie-heavy, near threshold
        for (int t = 0; t < 24; t++) begin
            for (int n = 0; n < N; n++) begin
                case (t % 3)
                    0: vec[n] = DW'($urandom);
                    1: vec[n] = DW'((int'($urandom_range(0, 4)) - 2) * 64);
                    default: vec[n] = DW'(int'($urandom_range(0, 64)) + 96);
                endcase
            end
            run_vec($sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
